// File: rtl/fila_ctrl_if.sv
// fila_ctrl_if: bundles every non-clock signal of the fila_ctrl queue sequencer.
//   Producers : req_a/req_b, data_a/data_b in; ack_a/ack_b out
//   Queue     : enqueue_out, data_out, dequeue_out out; queue_data_in, len_in in
//   Consumer  : pop_req in; pop_valid, pop_data, pop_empty out
//   Status    : count_out (controller occupancy), err_out (sticky length mismatch)
// The slave modport is the controller's view; the master modport is the view of
// the surrounding system (producers, consumer and the attached queue).
interface fila_ctrl_if #(
  parameter int QUEUE_DEPTH = 8,
  parameter int DATA_W      = 8
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  logic              req_a;
  logic              req_b;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic              ack_a;
  logic              ack_b;
  logic              enqueue_out;
  logic [DATA_W-1:0] data_out;
  logic              dequeue_out;
  logic [DATA_W-1:0] queue_data_in;
  logic [7:0]        len_in;
  logic              pop_req;
  logic              pop_valid;
  logic [DATA_W-1:0] pop_data;
  logic              pop_empty;
  logic [CNT_W-1:0]  count_out;
  logic              err_out;

  modport slave (
    input  req_a, req_b, data_a, data_b, queue_data_in, len_in, pop_req,
    output ack_a, ack_b, enqueue_out, data_out, dequeue_out,
           pop_valid, pop_data, pop_empty, count_out, err_out
  );

  modport master (
    output req_a, req_b, data_a, data_b, queue_data_in, len_in, pop_req,
    input  ack_a, ack_b, enqueue_out, data_out, dequeue_out,
           pop_valid, pop_data, pop_empty, count_out, err_out
  );
endinterface

// File: rtl/fila_ctrl.sv
// fila_ctrl: sequencer for the 8-bit LIFO queue (Fila) on the clock_10khz domain.
//   - Round-robin arbitration of producers A and B onto the single enqueue port.
//   - Pop FSM (IDLE -> ISSUE -> WAIT -> PRESENT) issuing dequeue pulses and
//     returning the popped element with a one-cycle valid strobe.
//   - Own occupancy count so the queue is never overfilled or over-drained.
// Ports:
//   clock_10khz : sole clock, rising edge
//   reset       : synchronous, active-high; the attached queue shares it
//   bus         : fila_ctrl_if.slave (producer, queue, consumer and status signals)
// Optional feature: define FILA_CTRL_LEN_CHECK_EN to compare the queue's len_in
// against the one-cycle-delayed count and raise the sticky err_out on mismatch.
// Without the macro err_out is tied low and no comparator exists.
module fila_ctrl #(
  parameter int QUEUE_DEPTH = 8,
  parameter int DATA_W      = 8
) (
  input logic        clock_10khz,
  input logic        reset,
  fila_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PRESENT} pop_state_t;

  pop_state_t       state, state_nxt;
  logic [CNT_W-1:0] count;
  logic             last_grant;   // 0: A won last, 1: B won last
  logic             issue_p0;
  logic             empty_p0;
  logic             elig_a_p0, elig_b_p0;
  logic             room_p0;
  logic             grant_a_p0, grant_b_p0;

  // Stage p0: pop FSM next state and same-cycle decisions
  always_comb begin
    state_nxt = state;
    issue_p0  = 1'b0;
    empty_p0  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.pop_req) begin
          if (count != '0) begin
            state_nxt = ISSUE;
            issue_p0  = 1'b1;
          end else begin
            empty_p0 = 1'b1;
          end
        end
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = PRESENT;
      PRESENT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A producer whose ack is high this cycle is ineligible, which is what
  // makes a lone requester wait a cycle and two requesters alternate.
  // When full, a pop issuing on this edge frees a slot, so a grant may ride
  // on the same edge and the count stays put.
  always_comb begin
    elig_a_p0  = bus.req_a & ~bus.ack_a;
    elig_b_p0  = bus.req_b & ~bus.ack_b;
    room_p0    = (count != DEPTH_C) | issue_p0;
    grant_a_p0 = room_p0 & elig_a_p0 & (~elig_b_p0 |  last_grant);
    grant_b_p0 = room_p0 & elig_b_p0 & (~elig_a_p0 | ~last_grant);
  end

  // Stage p1: registered pulses, count and pop data
  always_ff @(posedge clock_10khz) begin
    if (reset) begin
      state           <= IDLE;
      count           <= '0;
      last_grant      <= 1'b1;
      bus.ack_a       <= 1'b0;
      bus.ack_b       <= 1'b0;
      bus.enqueue_out <= 1'b0;
      bus.data_out    <= '0;
      bus.dequeue_out <= 1'b0;
      bus.pop_valid   <= 1'b0;
      bus.pop_data    <= '0;
      bus.pop_empty   <= 1'b0;
    end else begin
      state           <= state_nxt;
      bus.ack_a       <= grant_a_p0;
      bus.ack_b       <= grant_b_p0;
      bus.enqueue_out <= grant_a_p0 | grant_b_p0;
      if (grant_a_p0) begin
        bus.data_out <= bus.data_a;
        last_grant   <= 1'b0;
      end else if (grant_b_p0) begin
        bus.data_out <= bus.data_b;
        last_grant   <= 1'b1;
      end
      case ({grant_a_p0 | grant_b_p0, issue_p0})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
      bus.dequeue_out <= issue_p0;
      bus.pop_empty   <= empty_p0;
      bus.pop_valid   <= (state == WAIT);
      if (state == WAIT) bus.pop_data <= bus.queue_data_in;
    end
  end

  assign bus.count_out = count;

`ifdef FILA_CTRL_LEN_CHECK_EN
  logic [CNT_W-1:0] count_p1;
  logic             err;

  // Stage p2: the queue's length lags the controller count by one edge
  always_ff @(posedge clock_10khz) begin
    if (reset) begin
      count_p1 <= '0;
      err      <= 1'b0;
    end else begin
      count_p1 <= count;
      if (bus.len_in != 8'(count_p1)) err <= 1'b1;
    end
  end

  assign bus.err_out = err;
`else
  assign bus.err_out = 1'b0;
`endif

endmodule

// File: tb/tb_fila_ctrl.sv
// tb_fila_ctrl: directed bench for fila_ctrl with a small behavioural LIFO
// standing in for the attached queue. Inputs change and outputs are sampled
// on the falling edge of clock_10khz.
module tb_fila_ctrl;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  fila_ctrl_if #(.QUEUE_DEPTH(8), .DATA_W(8)) bus ();

  fila_ctrl #(.QUEUE_DEPTH(8), .DATA_W(8)) dut (
    .clock_10khz (clk),
    .reset       (reset),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Behavioural queue: len_out and popped data update on the edge after the pulse
  logic [7:0] mem [0:15];
  logic [7:0] q_len;
  logic [7:0] q_data;
  logic       len_ovr;
  logic [7:0] len_ovr_val;

  always @(posedge clk) begin
    if (reset) begin
      q_len  <= 8'd0;
      q_data <= 8'd0;
    end else begin
      if (bus.dequeue_out) q_data <= mem[q_len[3:0] - 4'd1];
      if (bus.enqueue_out)
        mem[bus.dequeue_out ? q_len[3:0] - 4'd1 : q_len[3:0]] <= bus.data_out;
      q_len <= q_len + {7'd0, bus.enqueue_out} - {7'd0, bus.dequeue_out};
    end
  end

  assign bus.queue_data_in = q_data;
  assign bus.len_in        = len_ovr ? len_ovr_val : q_len;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({bus.ack_a, bus.ack_b, bus.enqueue_out, bus.dequeue_out, bus.pop_valid,
         bus.pop_empty, bus.err_out} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_pulses: got %b expected 0000000",
               {bus.ack_a, bus.ack_b, bus.enqueue_out, bus.dequeue_out,
                bus.pop_valid, bus.pop_empty, bus.err_out});
    end
    n_cmp++;
    if (bus.count_out !== 4'd0) begin
      n_bad++; $display("FAIL reset_count: got %0d expected 0", bus.count_out);
    end
    n_cmp++;
    if ({bus.data_out, bus.pop_data} !== 16'h0) begin
      n_bad++; $display("FAIL reset_data: got %h expected 0000", {bus.data_out, bus.pop_data});
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    bus.req_a  = 1'b1;
    bus.data_a = 8'h3C;
    tick();
    n_cmp++;
    if ({bus.ack_a, bus.ack_b, bus.enqueue_out} !== 3'b101) begin
      n_bad++; $display("FAIL single_ack: got %b expected 101", {bus.ack_a, bus.ack_b, bus.enqueue_out});
    end
    n_cmp++;
    if (bus.data_out !== 8'h3C) begin
      n_bad++; $display("FAIL single_data: got %h expected 3c", bus.data_out);
    end
    n_cmp++;
    if (bus.count_out !== 4'd1) begin
      n_bad++; $display("FAIL single_count: got %0d expected 1", bus.count_out);
    end
    bus.req_a = 1'b0;
    tick();
    n_cmp++;
    if ({bus.ack_a, bus.enqueue_out} !== 2'b00) begin
      n_bad++; $display("FAIL single_drop: got %b expected 00", {bus.ack_a, bus.enqueue_out});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_a;
    logic [7:0] exp_d;
    exp_a = 4'b0101;   // bit i: grant i goes to A
    do_reset();
    bus.req_a  = 1'b1;
    bus.req_b  = 1'b1;
    bus.data_a = 8'h11;
    bus.data_b = 8'h22;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_d = exp_a[i] ? 8'h11 : 8'h22;
      n_cmp++;
      if ({bus.ack_a, bus.ack_b} !== {exp_a[i], ~exp_a[i]} || bus.data_out !== exp_d) begin
        n_bad++;
        $display("FAIL b2b_grant%0d: got ack_a/ack_b %b%b data %h expected %b%b data %h",
                 i, bus.ack_a, bus.ack_b, bus.data_out, exp_a[i], ~exp_a[i], exp_d);
      end
    end
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    tick();
    n_cmp++;
    if (bus.count_out !== 4'd4 || bus.enqueue_out !== 1'b0) begin
      n_bad++; $display("FAIL b2b_count: got %0d enq %b expected 4 enq 0", bus.count_out, bus.enqueue_out);
    end
  endtask

  task automatic test_full();
    do_reset();
    bus.req_a  = 1'b1;
    bus.req_b  = 1'b1;
    bus.data_a = 8'h11;
    bus.data_b = 8'h22;
    for (int i = 0; i < 8; i++) tick();
    n_cmp++;
    if (bus.count_out !== 4'd8) begin
      n_bad++; $display("FAIL full_fill: got %0d expected 8", bus.count_out);
    end
    bus.req_a = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus.ack_b !== 1'b0 || bus.enqueue_out !== 1'b0 || bus.count_out !== 4'd8) begin
      n_bad++;
      $display("FAIL full_stall: got ack_b %b enq %b count %0d expected 0 0 8",
               bus.ack_b, bus.enqueue_out, bus.count_out);
    end
    bus.pop_req = 1'b1;
    tick();
    n_cmp++;
    if ({bus.dequeue_out, bus.ack_b, bus.enqueue_out} !== 3'b111 || bus.count_out !== 4'd8) begin
      n_bad++;
      $display("FAIL full_swap: got deq/ack_b/enq %b count %0d expected 111 count 8",
               {bus.dequeue_out, bus.ack_b, bus.enqueue_out}, bus.count_out);
    end
    bus.pop_req = 1'b0;
    bus.req_b   = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus.pop_valid !== 1'b1 || bus.pop_data !== 8'h22 || bus.count_out !== 4'd8) begin
      n_bad++;
      $display("FAIL full_pop: got valid %b data %h count %0d expected 1 22 8",
               bus.pop_valid, bus.pop_data, bus.count_out);
    end
  endtask

  task automatic test_lifo();
    do_reset();
    bus.req_a  = 1'b1;
    bus.data_a = 8'h5A;
    tick();
    bus.req_a = 1'b0;
    tick();
    bus.req_a  = 1'b1;
    bus.data_a = 8'hA5;
    tick();
    bus.req_a   = 1'b0;
    bus.pop_req = 1'b1;
    tick();
    n_cmp++;
    if (bus.dequeue_out !== 1'b1 || bus.count_out !== 4'd1) begin
      n_bad++; $display("FAIL lifo_issue: got deq %b count %0d expected 1 1", bus.dequeue_out, bus.count_out);
    end
    bus.pop_req = 1'b0;
    tick();
    n_cmp++;
    if (bus.dequeue_out !== 1'b0 || bus.pop_valid !== 1'b0) begin
      n_bad++; $display("FAIL lifo_wait: got deq %b valid %b expected 0 0", bus.dequeue_out, bus.pop_valid);
    end
    tick();
    n_cmp++;
    if (bus.pop_valid !== 1'b1 || bus.pop_data !== 8'hA5 || bus.count_out !== 4'd1) begin
      n_bad++;
      $display("FAIL lifo_present: got valid %b data %h count %0d expected 1 a5 1",
               bus.pop_valid, bus.pop_data, bus.count_out);
    end
    tick();
    n_cmp++;
    if (bus.pop_valid !== 1'b0 || bus.pop_data !== 8'hA5) begin
      n_bad++; $display("FAIL lifo_hold: got valid %b data %h expected 0 a5", bus.pop_valid, bus.pop_data);
    end
  endtask

  task automatic test_empty();
    do_reset();
    bus.pop_req = 1'b1;
    tick();
    n_cmp++;
    if (bus.pop_empty !== 1'b1 || bus.dequeue_out !== 1'b0) begin
      n_bad++; $display("FAIL empty_pulse: got empty %b deq %b expected 1 0", bus.pop_empty, bus.dequeue_out);
    end
    bus.pop_req = 1'b0;
    tick();
    n_cmp++;
    if (bus.pop_empty !== 1'b0 || bus.count_out !== 4'd0) begin
      n_bad++; $display("FAIL empty_drop: got empty %b count %0d expected 0 0", bus.pop_empty, bus.count_out);
    end
  endtask

  task automatic test_len_check();
    logic exp_err;
`ifdef FILA_CTRL_LEN_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    bus.data_a = 8'h01;
    bus.req_a  = 1'b1;
    tick();
    bus.req_a = 1'b0;
    tick();
    bus.req_a = 1'b1;
    tick();
    bus.req_a = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus.err_out !== 1'b0 || bus.count_out !== 4'd2) begin
      n_bad++; $display("FAIL len_clean: got err %b count %0d expected 0 2", bus.err_out, bus.count_out);
    end
    len_ovr     = 1'b1;
    len_ovr_val = 8'd3;
    tick();
    len_ovr = 1'b0;
    n_cmp++;
    if (bus.err_out !== exp_err) begin
      n_bad++; $display("FAIL len_set: got %b expected %b", bus.err_out, exp_err);
    end
    tick();
    tick();
    n_cmp++;
    if (bus.err_out !== exp_err) begin
      n_bad++; $display("FAIL len_sticky: got %b expected %b", bus.err_out, exp_err);
    end
    do_reset();
    n_cmp++;
    if (bus.err_out !== 1'b0) begin
      n_bad++; $display("FAIL len_clear: got %b expected 0", bus.err_out);
    end
  endtask

  task automatic test_reset_mid_pop();
    do_reset();
    bus.req_a  = 1'b1;
    bus.data_a = 8'h77;
    tick();
    bus.req_a = 1'b0;
    tick();
    bus.pop_req = 1'b1;
    tick();
    bus.pop_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({bus.ack_a, bus.ack_b, bus.enqueue_out, bus.dequeue_out, bus.pop_valid,
         bus.pop_empty, bus.err_out} !== 7'b0 || bus.count_out !== 4'd0 ||
        bus.pop_data !== 8'h00) begin
      n_bad++;
      $display("FAIL midpop_reset: got pulses %b count %0d data %h expected 0000000 0 00",
               {bus.ack_a, bus.ack_b, bus.enqueue_out, bus.dequeue_out, bus.pop_valid,
                bus.pop_empty, bus.err_out}, bus.count_out, bus.pop_data);
    end
    reset = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus.pop_valid !== 1'b0 || bus.dequeue_out !== 1'b0) begin
      n_bad++; $display("FAIL midpop_after: got valid %b deq %b expected 0 0", bus.pop_valid, bus.dequeue_out);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    reset       = 1'b1;
    bus.req_a   = 1'b0;
    bus.req_b   = 1'b0;
    bus.data_a  = 8'h00;
    bus.data_b  = 8'h00;
    bus.pop_req = 1'b0;
    len_ovr     = 1'b0;
    len_ovr_val = 8'd0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_lifo();
    test_empty();
    test_len_check();
    test_reset_mid_pop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
